// File: rtl/array_arbiter.sv
// Two-requester round-robin arbiter in front of a small register-array memory.
// After reset the array is filled with mem[a] = a before any request is accepted.
module array_arbiter #(
  parameter int WA = 8,
  parameter int WB = 8,
  localparam int AW = (WA > 1) ? $clog2(WA) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_vld,
  input  logic          req0_wen,
  input  logic [AW-1:0] req0_adr,
  input  logic [WB-1:0] req0_wdt,
  output logic          req0_rdy,
  input  logic          req1_vld,
  input  logic          req1_wen,
  input  logic [AW-1:0] req1_adr,
  input  logic [WB-1:0] req1_wdt,
  output logic          req1_rdy,
  output logic          rsp_vld,
  output logic          rsp_id,
  output logic [WB-1:0] rsp_rdt,
  output logic          init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(WA - 1);

  logic [WB-1:0] mem [WA-1:0];

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] init_adr_r;
  logic [AW-1:0] init_adr_nxt_s;
  logic          last_gnt_r;

  logic          run_s;
  logic          gnt_any_s;
  logic          gnt_s;
  logic          xfer_s;
  logic          xfer_wen_s;
  logic [AW-1:0] xfer_adr_s;
  logic [WB-1:0] xfer_wdt_s;
  logic          in_range_s;
  logic          mem_we_s;
  logic          rd_xfer_s;

  logic          rsp_vld_r;
  logic          rsp_id_r;
  logic [WB-1:0] rsp_rdt_r;

  assign run_s = (state_r == ST_RUN);

  // Round-robin choice: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_s     = 1'b0;
    if (req0_vld && req1_vld) begin
      gnt_any_s = 1'b1;
      gnt_s     = ~last_gnt_r;
    end else if (req0_vld) begin
      gnt_any_s = 1'b1;
      gnt_s     = 1'b0;
    end else if (req1_vld) begin
      gnt_any_s = 1'b1;
      gnt_s     = 1'b1;
    end else begin
      gnt_any_s = 1'b0;
      gnt_s     = 1'b0;
    end
  end

  assign req0_rdy = run_s & gnt_any_s & ~gnt_s;
  assign req1_rdy = run_s & gnt_any_s & gnt_s;
  assign xfer_s   = (req0_vld & req0_rdy) | (req1_vld & req1_rdy);

  // Payload of the granted requester
  always_comb begin
    xfer_wen_s = 1'b0;
    xfer_adr_s = '0;
    xfer_wdt_s = '0;
    if (gnt_s) begin
      xfer_wen_s = req1_wen;
      xfer_adr_s = req1_adr;
      xfer_wdt_s = req1_wdt;
    end else begin
      xfer_wen_s = req0_wen;
      xfer_adr_s = req0_adr;
      xfer_wdt_s = req0_wdt;
    end
  end

  // A power-of-two depth has no out-of-range addresses at all
  if (WA == (1 << AW)) begin : g_full
    assign in_range_s = 1'b1;
  end else begin : g_part
    assign in_range_s = (xfer_adr_s < AW'(WA));
  end

  assign mem_we_s  = xfer_s & xfer_wen_s & in_range_s;
  assign rd_xfer_s = xfer_s & ~xfer_wen_s;

  // Next-state logic: INIT walks the address range once, RUN is terminal until reset
  always_comb begin
    state_nxt_s    = state_r;
    init_adr_nxt_s = init_adr_r;
    case (state_r)
      ST_INIT: begin
        if (init_adr_r == LAST_ADR) begin
          state_nxt_s    = ST_RUN;
          init_adr_nxt_s = '0;
        end else begin
          init_adr_nxt_s = init_adr_r + AW'(1);
        end
      end
      ST_RUN: begin
        state_nxt_s    = ST_RUN;
        init_adr_nxt_s = '0;
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_adr_nxt_s = '0;
      end
    endcase
  end

  // State, fill pointer and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_adr_r <= '0;
      last_gnt_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      init_adr_r <= init_adr_nxt_s;
      if (xfer_s) begin
        last_gnt_r <= gnt_s;
      end
    end
  end

  // Storage is deliberately not reset; INIT rewrites every entry
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem[init_adr_r] <= WB'(init_adr_r);
    end else if (mem_we_s) begin
      mem[xfer_adr_s] <= xfer_wdt_s;
    end
  end

  // Read response one cycle after the transfer; id/data hold while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_r <= 1'b0;
      rsp_id_r  <= 1'b0;
      rsp_rdt_r <= '0;
    end else begin
      rsp_vld_r <= rd_xfer_s;
      if (rd_xfer_s) begin
        rsp_id_r  <= gnt_s;
        rsp_rdt_r <= in_range_s ? mem[xfer_adr_s] : '0;
      end
    end
  end

  assign rsp_vld   = rsp_vld_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_rdt   = rsp_rdt_r;
  assign init_done = run_s;

endmodule

// File: tb/tb_array_arbiter.sv
// Drives four array_arbiter configurations from shared stimulus and checks every
// cycle against a per-instance behavioural model (memory array + last-grant flag).
module tb_array_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
  logic [3:0] a0 = 4'd0, a1 = 4'd0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0;

  wire [3:0] o_rdy0, o_rdy1, o_done, o_rvld, o_rid;
  wire [7:0] o_rdt [4];
  wire [2:0] rdt_n2, rdt_n3;

  int n_chk  = 0;
  int n_fail = 0;

  int wa [4] = '{8, 9, 10, 8};
  int wb [4] = '{8, 8, 3, 3};
  int aw [4] = '{3, 4, 4, 3};
  int mem_m [4][16];
  int last_m [4];
  int cnt [4];
  int e_rvld [4];
  int e_rid [4];
  int e_rdt [4];

  always #5 clk = ~clk;

  array_arbiter #(.WA(8), .WB(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_vld(v0), .req0_wen(w0), .req0_adr(a0[2:0]), .req0_wdt(d0), .req0_rdy(o_rdy0[0]),
    .req1_vld(v1), .req1_wen(w1), .req1_adr(a1[2:0]), .req1_wdt(d1), .req1_rdy(o_rdy1[0]),
    .rsp_vld(o_rvld[0]), .rsp_id(o_rid[0]), .rsp_rdt(o_rdt[0]), .init_done(o_done[0])
  );

  array_arbiter #(.WA(9), .WB(8)) u_d9 (
    .clk(clk), .rst(rst),
    .req0_vld(v0), .req0_wen(w0), .req0_adr(a0), .req0_wdt(d0), .req0_rdy(o_rdy0[1]),
    .req1_vld(v1), .req1_wen(w1), .req1_adr(a1), .req1_wdt(d1), .req1_rdy(o_rdy1[1]),
    .rsp_vld(o_rvld[1]), .rsp_id(o_rid[1]), .rsp_rdt(o_rdt[1]), .init_done(o_done[1])
  );

  array_arbiter #(.WA(10), .WB(3)) u_d10 (
    .clk(clk), .rst(rst),
    .req0_vld(v0), .req0_wen(w0), .req0_adr(a0), .req0_wdt(d0[2:0]), .req0_rdy(o_rdy0[2]),
    .req1_vld(v1), .req1_wen(w1), .req1_adr(a1), .req1_wdt(d1[2:0]), .req1_rdy(o_rdy1[2]),
    .rsp_vld(o_rvld[2]), .rsp_id(o_rid[2]), .rsp_rdt(rdt_n2), .init_done(o_done[2])
  );

  array_arbiter #(.WA(8), .WB(3)) u_d83 (
    .clk(clk), .rst(rst),
    .req0_vld(v0), .req0_wen(w0), .req0_adr(a0[2:0]), .req0_wdt(d0[2:0]), .req0_rdy(o_rdy0[3]),
    .req1_vld(v1), .req1_wen(w1), .req1_adr(a1[2:0]), .req1_wdt(d1[2:0]), .req1_rdy(o_rdy1[3]),
    .rsp_vld(o_rvld[3]), .rsp_id(o_rid[3]), .rsp_rdt(rdt_n3), .init_done(o_done[3])
  );

  assign o_rdt[2] = {5'b00000, rdt_n2};
  assign o_rdt[3] = {5'b00000, rdt_n3};

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      last_m[i] = 1;
      e_rvld[i] = 0;
      e_rid[i]  = 0;
      e_rdt[i]  = 0;
      cnt[i]    = 0;
      for (int a = 0; a < 16; a++)
        mem_m[i][a] = (a < wa[i]) ? (a & ((1 << wb[i]) - 1)) : 0;
    end
  endtask

  // Called at a negedge; raises rst mid-cycle, checks outputs clear at once, releases at the next negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_init_done", i, o_done[i], 0);
      chk("rst_rdy0", i, o_rdy0[i], 0);
      chk("rst_rdy1", i, o_rdy1[i], 0);
      chk("rst_rsp_vld", i, o_rvld[i], 0);
      chk("rst_rsp_id", i, o_rid[i], 0);
      chk("rst_rsp_rdt", i, o_rdt[i], 0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: inputs already driven at the negedge; checks handshake, then response.
  task automatic step();
    int nv [4];
    int nid [4];
    int nrdt [4];
    int g, ea, dat, mask;
    bit run, wen, inr;
    #1;
    for (int i = 0; i < 4; i++) begin
      run = (cnt[i] >= wa[i]);
      g = -1;
      if (v0 && v1) g = (last_m[i] == 0) ? 1 : 0;
      else if (v0) g = 0;
      else if (v1) g = 1;
      if (!run) g = -1;
      chk("init_done", i, o_done[i], run);
      chk("rdy0", i, o_rdy0[i], (g == 0));
      chk("rdy1", i, o_rdy1[i], (g == 1));
      nv[i]   = 0;
      nid[i]  = e_rid[i];
      nrdt[i] = e_rdt[i];
      if (g >= 0) begin
        wen  = (g == 1) ? w1 : w0;
        ea   = ((g == 1) ? a1 : a0) & ((1 << aw[i]) - 1);
        mask = (1 << wb[i]) - 1;
        dat  = ((g == 1) ? d1 : d0) & mask;
        inr  = (ea < wa[i]);
        if (wen) begin
          if (inr) mem_m[i][ea] = dat;
        end else begin
          nv[i]   = 1;
          nid[i]  = g;
          nrdt[i] = inr ? mem_m[i][ea] : 0;
        end
        last_m[i] = g;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      cnt[i]++;
      e_rvld[i] = nv[i];
      e_rid[i]  = nid[i];
      e_rdt[i]  = nrdt[i];
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rsp_vld", i, o_rvld[i], e_rvld[i]);
      chk("rsp_id", i, o_rid[i], e_rid[i]);
      chk("rsp_rdt", i, o_rdt[i], e_rdt[i]);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 3; k++) step();

    // Reset on the 4th INIT cycle with a read already pending on req0
    v0 = 1'b1; w0 = 1'b0; a0 = 4'd5;
    do_reset();
    for (int k = 0; k < 9; k++) step();
    chk("first_read_id", 0, o_rid[0], 0);
    chk("first_read_rdt", 0, o_rdt[0], 8'h05);
    step();
    v0 = 1'b0;
    step();

    // Both requesters hold reads: grants and responses alternate
    v0 = 1'b1; w0 = 1'b0; a0 = 4'd1;
    v1 = 1'b1; w1 = 1'b0; a1 = 4'd2;
    for (int k = 0; k < 4; k++) step();
    v0 = 1'b0; v1 = 1'b0;
    step();

    // Write by req1 followed directly by a read of the same entry by req0
    v1 = 1'b1; w1 = 1'b1; a1 = 4'd3; d1 = 8'hA5;
    step();
    v1 = 1'b0;
    v0 = 1'b1; w0 = 1'b0; a0 = 4'd3;
    step();
    chk("raw_rdt", 0, o_rdt[0], 8'hA5);
    chk("raw_id", 0, o_rid[0], 0);

    // Truncated init data
    a0 = 4'd9;
    step();
    chk("trunc_wa10_adr9", 2, o_rdt[2], 3'b001);
    a0 = 4'd7;
    step();
    chk("trunc_wa8_adr7", 3, o_rdt[3], 3'b111);

    // Out-of-range write dropped, read returns zero, neighbour untouched
    w0 = 1'b1; a0 = 4'd9; d0 = 8'hFF;
    step();
    chk("oor_wr_no_rsp", 1, o_rvld[1], 0);
    w0 = 1'b0; a0 = 4'd9;
    step();
    chk("oor_rd_rdt", 1, o_rdt[1], 8'h00);
    a0 = 4'd1;
    step();
    chk("oor_neighbour", 1, o_rdt[1], 8'h01);
    v0 = 1'b0;
    step();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      v0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom_range(0, 15)); d0 = 8'($urandom);
      v1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a1 = 4'($urandom_range(0, 15)); d1 = 8'($urandom);
      step();
    end

    // Reset while a read response is on the outputs
    v0 = 1'b0; v1 = 1'b1; w1 = 1'b0; a1 = 4'd2;
    step();
    v1 = 1'b0;
    do_reset();
    for (int k = 0; k < 11; k++) step();
    for (int k = 0; k < 60; k++) begin
      v0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom_range(0, 15)); d0 = 8'($urandom);
      v1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a1 = 4'($urandom_range(0, 15)); d1 = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
